// File: rtl/audio_pkg.sv
// Shared types and helpers for the two-clip audio recorder.
// Holds the controller state encoding and the 7-segment digit codes.
package audio_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RECORD,
      PLAY
   } state_t;

   // Active-low cathodes, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;

   function automatic logic [6:0] seg_digit(input logic digit);
      return digit ? SEG_1 : SEG_0;
   endfunction

endpackage

// File: rtl/pdm_deserializer.sv
// PDM microphone front end: generates the mic clock, samples the bitstream on
// each rising mic-clock edge and decimates it to PCM by saturating ones-count.
module pdm_deserializer #(
   parameter int unsigned CLK_FREQ_MHZ = 100,
   parameter int unsigned SAMPLE_BITS  = 10
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   pdm_data_i,
   output logic                   pdm_clk_o,
   output logic [SAMPLE_BITS-1:0] sample_o,
   output logic                   sample_valid_o
);

   localparam int unsigned HALF_PERIOD = CLK_FREQ_MHZ / 5;
   localparam int unsigned DIV_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(HALF_PERIOD - 1);
   localparam logic [SAMPLE_BITS-1:0] ALL_ONES = '1;

   logic [DIV_W-1:0]       r_div_cnt;
   logic                   r_pdm_clk;
   logic [SAMPLE_BITS-1:0] r_bit_cnt;
   logic [SAMPLE_BITS-1:0] r_ones;
   logic [SAMPLE_BITS-1:0] r_sample;
   logic                   r_sample_valid;

   logic                   w_toggle;
   logic                   w_rise;
   logic [SAMPLE_BITS-1:0] w_ones_next;

   assign w_toggle = (r_div_cnt == DIV_LAST);
   assign w_rise   = w_toggle & ~r_pdm_clk;

   always_comb begin
      w_ones_next = r_ones;
      if (pdm_data_i && (r_ones != ALL_ONES)) begin
         w_ones_next = r_ones + 1'b1;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_div_cnt      <= '0;
         r_pdm_clk      <= 1'b0;
         r_bit_cnt      <= '0;
         r_ones         <= '0;
         r_sample       <= '0;
         r_sample_valid <= 1'b0;
      end else begin
         r_sample_valid <= 1'b0;
         if (w_toggle) begin
            r_div_cnt <= '0;
            r_pdm_clk <= ~r_pdm_clk;
         end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
         end
         // Data is taken in the same clock that drives the mic clock high
         if (w_rise) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == ALL_ONES) begin
               r_sample       <= w_ones_next;
               r_sample_valid <= 1'b1;
               r_ones         <= '0;
            end else begin
               r_ones <= w_ones_next;
            end
         end
      end
   end

   assign pdm_clk_o      = r_pdm_clk;
   assign sample_o       = r_sample;
   assign sample_valid_o = r_sample_valid;

endmodule

// File: rtl/audio_clip_recorder.sv
// Two-clip voice recorder/player: PDM mic capture into on-chip clip RAM and
// PWM playback, with 7-segment display of the selected play/record clips.
module audio_clip_recorder
   import audio_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned CLK_FREQ_MHZ = 100,
   parameter int unsigned SAMPLE_BITS  = 10
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       play_i,
   input  logic       record_i,
   input  logic       play_clip_select_i,
   input  logic       record_clip_select_i,
   output logic [6:0] cathode_play_o,
   output logic [6:0] cathode_record_o,
   output logic       pdm_clk_o,
   input  logic       pdm_data_i,
   output logic       pdm_lrsel_o,
   output logic       pwm_audio_o,
   output logic       pwm_sdaudio_o
);

   localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
   localparam int unsigned LEN_W  = ADDR_WIDTH + 1;
   localparam int unsigned PERIOD = (2 ** SAMPLE_BITS) * 2 * (CLK_FREQ_MHZ / 5);
   localparam int unsigned TICK_W = $clog2(PERIOD);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD - 1);
   localparam logic [LEN_W-1:0]  ADDR_LAST = LEN_W'(DEPTH - 1);

   logic                   r_play;
   logic                   r_play_prev;
   logic                   r_rec;
   logic                   r_rec_prev;
   logic                   r_play_sel;
   logic                   r_rec_sel;
   logic [6:0]             r_cath_play;
   logic [6:0]             r_cath_rec;
   state_t                 r_state;
   logic                   r_clip;
   logic [LEN_W-1:0]       r_addr;
   logic [TICK_W-1:0]      r_tick;
   logic [LEN_W-1:0]       r_len [2];
   logic [SAMPLE_BITS-1:0] r_mem [2*DEPTH];
   logic [SAMPLE_BITS-1:0] r_rd_data;

   state_t                 w_state_next;
   logic                   w_play_cmd;
   logic                   w_rec_cmd;
   logic                   w_wr_en;
   logic                   w_period_end;
   logic [LEN_W-1:0]       w_addr_inc;
   logic [LEN_W-1:0]       w_written;
   logic                   w_rd_clip;
   logic [ADDR_WIDTH-1:0]  w_rd_addr;
   logic [ADDR_WIDTH:0]    w_rd_idx;
   logic [ADDR_WIDTH:0]    w_wr_idx;
   logic [SAMPLE_BITS-1:0] w_sample;
   logic                   w_sample_valid;
   logic [SAMPLE_BITS-1:0] w_pwm_cnt;

   pdm_deserializer #(
      .CLK_FREQ_MHZ (CLK_FREQ_MHZ),
      .SAMPLE_BITS  (SAMPLE_BITS)
   ) u_pdm (
      .clock_i        (clock_i),
      .reset_i        (reset_i),
      .pdm_data_i     (pdm_data_i),
      .pdm_clk_o      (pdm_clk_o),
      .sample_o       (w_sample),
      .sample_valid_o (w_sample_valid)
   );

   assign w_play_cmd   = r_play & ~r_play_prev;
   assign w_rec_cmd    = r_rec & ~r_rec_prev;
   assign w_wr_en      = (r_state == RECORD) & w_sample_valid;
   assign w_period_end = (r_tick == TICK_LAST);
   assign w_addr_inc   = r_addr + 1'b1;
   assign w_written    = w_wr_en ? w_addr_inc : r_addr;
   assign w_wr_idx     = {r_clip, r_addr[ADDR_WIDTH-1:0]};
   assign w_rd_idx     = {w_rd_clip, w_rd_addr};

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_rec_cmd) begin
               w_state_next = RECORD;
            end else if (w_play_cmd && (r_len[r_play_sel] != '0)) begin
               w_state_next = PLAY;
            end
         end
         RECORD: begin
            if (w_rec_cmd || (w_wr_en && (r_addr == ADDR_LAST))) begin
               w_state_next = IDLE;
            end
         end
         PLAY: begin
            if (w_play_cmd || (w_period_end && (w_addr_inc == r_len[r_clip]))) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Read port always points at the sample needed next cycle, so the sample
   // for a period is already in r_rd_data at its first clock.
   always_comb begin
      w_rd_clip = r_play_sel;
      w_rd_addr = '0;
      if (r_state == PLAY) begin
         w_rd_clip = r_clip;
         w_rd_addr = w_period_end ? w_addr_inc[ADDR_WIDTH-1:0] : r_addr[ADDR_WIDTH-1:0];
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_play      <= 1'b0;
         r_play_prev <= 1'b0;
         r_rec       <= 1'b0;
         r_rec_prev  <= 1'b0;
         r_play_sel  <= 1'b0;
         r_rec_sel   <= 1'b0;
         r_cath_play <= SEG_0;
         r_cath_rec  <= SEG_0;
         r_state     <= IDLE;
         r_clip      <= 1'b0;
         r_addr      <= '0;
         r_tick      <= '0;
         r_len[0]    <= '0;
         r_len[1]    <= '0;
      end else begin
         r_play      <= play_i;
         r_play_prev <= r_play;
         r_rec       <= record_i;
         r_rec_prev  <= r_rec;
         r_play_sel  <= play_clip_select_i;
         r_rec_sel   <= record_clip_select_i;
         r_cath_play <= seg_digit(play_clip_select_i);
         r_cath_rec  <= seg_digit(record_clip_select_i);
         r_state     <= w_state_next;
         unique case (r_state)
            IDLE: begin
               if (w_rec_cmd) begin
                  r_clip           <= r_rec_sel;
                  r_addr           <= '0;
                  r_len[r_rec_sel] <= '0;
               end else if (w_state_next == PLAY) begin
                  r_clip <= r_play_sel;
                  r_addr <= '0;
                  r_tick <= '0;
               end
            end
            RECORD: begin
               if (w_wr_en) begin
                  r_addr <= w_addr_inc;
               end
               if (w_state_next == IDLE) begin
                  r_len[r_clip] <= w_written;
               end
            end
            PLAY: begin
               if (w_period_end) begin
                  r_tick <= '0;
                  r_addr <= w_addr_inc;
               end else begin
                  r_tick <= r_tick + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Clip storage is deliberately not reset
   always_ff @(posedge clock_i) begin
      if (w_wr_en && !reset_i) begin
         r_mem[w_wr_idx] <= w_sample;
      end
      r_rd_data <= r_mem[w_rd_idx];
   end

   assign w_pwm_cnt        = r_tick[SAMPLE_BITS-1:0];
   assign pwm_sdaudio_o    = (r_state == PLAY);
   assign pwm_audio_o      = (r_state == PLAY) && (w_pwm_cnt < r_rd_data);
   assign pdm_lrsel_o      = 1'b0;
   assign cathode_play_o   = r_cath_play;
   assign cathode_record_o = r_cath_rec;

endmodule

// File: tb/tb_audio_clip_recorder.sv
// Directed bench for audio_clip_recorder with a small configuration
// (16-sample clips, 4-bit samples, 640-clock sample period).
module tb_audio_clip_recorder;

   localparam int unsigned AW   = 4;
   localparam int unsigned CF   = 100;
   localparam int unsigned SB   = 4;
   localparam int          SPER = 640;

   logic       clock_i = 1'b0;
   logic       reset_i = 1'b1;
   logic       play_i = 1'b0;
   logic       record_i = 1'b0;
   logic       play_sel = 1'b0;
   logic       rec_sel = 1'b0;
   logic       pdm_data = 1'b0;
   logic [6:0] cath_play;
   logic [6:0] cath_rec;
   logic       pdm_clk;
   logic       pdm_lrsel;
   logic       pwm_audio;
   logic       pwm_sd;

   int n_checks = 0;
   int n_fail = 0;
   int pdm_rises = 0;
   int base = 0;

   audio_clip_recorder #(
      .ADDR_WIDTH   (AW),
      .CLK_FREQ_MHZ (CF),
      .SAMPLE_BITS  (SB)
   ) dut (
      .clock_i              (clock_i),
      .reset_i              (reset_i),
      .play_i               (play_i),
      .record_i             (record_i),
      .play_clip_select_i   (play_sel),
      .record_clip_select_i (rec_sel),
      .cathode_play_o       (cath_play),
      .cathode_record_o     (cath_rec),
      .pdm_clk_o            (pdm_clk),
      .pdm_data_i           (pdm_data),
      .pdm_lrsel_o          (pdm_lrsel),
      .pwm_audio_o          (pwm_audio),
      .pwm_sdaudio_o        (pwm_sd)
   );

   always #5 clock_i = ~clock_i;
   always @(posedge pdm_clk) pdm_rises++;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic pulse(input bit do_play, input bit do_rec, input int cycles);
      @(negedge clock_i);
      play_i = do_play;
      record_i = do_rec;
      repeat (cycles) @(negedge clock_i);
      play_i = 1'b0;
      record_i = 1'b0;
   endtask

   task automatic count_sd(input int cycles, output int sd_n, output int pwm_n);
      sd_n = 0;
      pwm_n = 0;
      repeat (cycles) begin
         @(negedge clock_i);
         if (pwm_sd) sd_n++;
         if (pwm_audio) pwm_n++;
      end
   endtask

   task automatic wait_sd(input int bound, output int seen);
      seen = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clock_i);
         if (pwm_sd) begin
            seen = 1;
            break;
         end
      end
   endtask

   task automatic measure_play(output int sd_n, output int pwm_n);
      sd_n = 0;
      pwm_n = 0;
      while (pwm_sd && sd_n < 20000) begin
         sd_n++;
         if (pwm_audio) pwm_n++;
         @(negedge clock_i);
      end
   endtask

   task automatic wait_rises(input int target_mod, input int target_abs, output int ok);
      ok = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clock_i);
         if (target_abs >= 0 && (pdm_rises - base) == target_abs) begin
            ok = 1;
            break;
         end
         if (target_abs < 0 && ((pdm_rises - base) % 16) == target_mod) begin
            ok = 1;
            break;
         end
      end
   endtask

   initial begin
      int a, b, seen, ok, s;

      // Reset state
      repeat (2) @(negedge clock_i);
      check("reset_cath_play", int'(cath_play), 7'b1000000);
      check("reset_cath_rec", int'(cath_rec), 7'b1000000);
      check("reset_pdm_clk", int'(pdm_clk), 0);
      check("reset_sd", int'(pwm_sd), 0);
      check("reset_pwm", int'(pwm_audio), 0);
      check("lrsel", int'(pdm_lrsel), 0);
      reset_i = 1'b0;
      base = pdm_rises;
      pdm_data = 1'b1;

      // Play on an empty clip is ignored
      pulse(1'b1, 1'b0, 3);
      count_sd(50, a, b);
      check("empty_play_sd", a, 0);
      check("empty_play_pwm", b, 0);
      check("idle_cath_play", int'(cath_play), 7'b1000000);
      check("idle_cath_rec", int'(cath_rec), 7'b1000000);

      // Record clip 1 with all-ones PDM data
      rec_sel = 1'b1;
      repeat (2) @(negedge clock_i);
      check("cath_rec_1", int'(cath_rec), 7'b1111001);
      pulse(1'b0, 1'b1, 1);
      repeat (14 * SPER) @(negedge clock_i);
      play_sel = 1'b1;
      pulse(1'b1, 1'b0, 1);
      count_sd(20, a, b);
      check("play_during_rec", a, 0);
      repeat (3 * SPER) @(negedge clock_i);

      // Play clip 1: 16 periods, PWM duty 15/16
      pulse(1'b1, 1'b0, 1);
      wait_sd(10, seen);
      check("play1_start", seen, 1);
      measure_play(a, b);
      check("play1_sd_cycles", a, 16 * SPER);
      check("play1_pwm_high", b, 16 * SPER * 15 / 16);
      check("play1_end_sd", int'(pwm_sd), 0);
      check("play1_end_pwm", int'(pwm_audio), 0);

      // Record clip 0 with zero data, stopped after 3 samples
      pdm_data = 1'b0;
      rec_sel = 1'b0;
      play_sel = 1'b0;
      repeat (17 * 40) @(negedge clock_i);
      wait_rises(1, -1, ok);
      check("align_window", ok, 1);
      s = pdm_rises - base;
      pulse(1'b0, 1'b1, 1);
      wait_rises(0, s + 55, ok);
      check("align_stop", ok, 1);
      pulse(1'b0, 1'b1, 1);
      repeat (5) @(negedge clock_i);
      pulse(1'b1, 1'b0, 1);
      wait_sd(10, seen);
      check("play0_start", seen, 1);
      measure_play(a, b);
      check("play0_sd_cycles", a, 3 * SPER);
      check("play0_pwm_high", b, 0);

      // Simultaneous edges: record wins, play ignored while recording
      pdm_data = 1'b1;
      play_sel = 1'b1;
      rec_sel = 1'b0;
      pulse(1'b1, 1'b1, 1);
      count_sd(100, a, b);
      check("simul_no_play", a, 0);
      pulse(1'b1, 1'b0, 1);
      count_sd(100, a, b);
      check("rec_ignores_play", a, 0);
      repeat (3 * SPER) @(negedge clock_i);
      pulse(1'b0, 1'b1, 1);
      repeat (5) @(negedge clock_i);
      play_sel = 1'b0;
      pulse(1'b1, 1'b0, 1);
      wait_sd(10, seen);
      check("simul_recorded", seen, 1);
      repeat (100) @(negedge clock_i);

      // Reset during playback
      reset_i = 1'b1;
      @(negedge clock_i);
      check("rst_play_sd", int'(pwm_sd), 0);
      check("rst_play_pwm", int'(pwm_audio), 0);
      check("rst_play_pdm_clk", int'(pdm_clk), 0);
      reset_i = 1'b0;
      pulse(1'b1, 1'b0, 1);
      count_sd(50, a, b);
      check("post_rst_clip0", a, 0);
      play_sel = 1'b1;
      repeat (2) @(negedge clock_i);
      pulse(1'b1, 1'b0, 1);
      count_sd(50, a, b);
      check("post_rst_clip1", a, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
